mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the
//  MA stage (load/store) of the 5-stage RV32I pipeline. Arbitrates, drives the memory handshake, and
//  returns read data to the owner. MA has priority; a burst limiter guarantees IF forward progress.
// PARAMETERS
//  MAX_MA_BURST  4   consecutive MA grants allowed while if_req is pending before IF is forced (1..15)
//  AW            32  address width
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high reset
//  if_req     in   1   fetch request; held high until if_valid
//  if_addr    in   AW  fetch address, stable while if_req
//  if_gnt     out  1   1-cycle pulse: IF request accepted
//  if_valid   out  1   1-cycle pulse: if_rdata valid, transaction done
//  if_rdata   out  32  fetched instruction
//  ma_req     in   1   data request; held high until ma_valid
//  ma_we      in   1   1 = store, 0 = load
//  ma_addr    in   AW  data address
//  ma_wdata   in   32  store data
//  ma_wstrb   in   4   byte enables (store only)
//  ma_gnt     out  1   1-cycle pulse: MA request accepted
//  ma_valid   out  1   1-cycle pulse: transaction done (ma_rdata valid for loads)
//  ma_rdata   out  32  load data
//  mem_req    out  1   memory request, held until mem_ack
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  32  memory write data
//  mem_wstrb  out  4   memory byte enables (4'b0000 on reads)
//  mem_ack    in   1   1-cycle pulse: access complete, mem_rdata valid same cycle
//  mem_rdata  in   32  memory read data
//  perf_if_wait   out 32  cycles if_req high while not owning memory (optional feature)
//  perf_conflict  out 32  IDLE cycles with if_req and ma_req both high (optional feature)
// BEHAVIOUR
//  - Reset: state IDLE, burst_cnt 0; all outputs 0 (gnt, valid, mem_req, mem_we, rdata, mem_* buses).
//  - FSM states IDLE, BUSY_IF, BUSY_MA.
//  - IDLE: if ma_req and not (if_req and burst_cnt==MAX_MA_BURST) -> grant MA, go BUSY_MA;
//    else if if_req -> grant IF, go BUSY_IF; else stay. Grant pulses x_gnt in the same cycle;
//    request fields latched into mem_* registers, mem_req asserted from the next cycle.
//  - burst_cnt: +1 on MA grant while if_req high (saturates at MAX_MA_BURST); cleared on IF grant
//    or any IDLE cycle with if_req low.
//  - BUSY_x: mem_* held constant while mem_req high. On mem_ack: mem_req drops same edge,
//    x_rdata <= mem_rdata, x_valid pulses next cycle, state -> IDLE. Minimum latency
//    grant->valid = 2 + memory wait cycles; one IDLE bubble between back-to-back transactions.
//  - x_rdata holds last value until next completion to that requester. Store: ma_rdata unchanged.
//  - mem_ack while IDLE (spurious): ignored, no valid pulse.
//  - Requester dropping req while BUSY is illegal; arbiter completes the access regardless.
//  - Reset mid-transaction: FSM to IDLE, mem_req drops on that edge; a later mem_ack is ignored.
//  - Requests are only sampled in IDLE; x_valid and new grant to the same requester never coincide.
// CONFIGURATION
//  MEM_ARB_PERF_CNT_EN defined: perf_if_wait and perf_conflict count as defined above, wrap at 2^32,
//  cleared by reset. Not defined: both ports tied to 32'd0, no counter flops.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE/BUSY_IF/BUSY_MA), owner encoding, MEM_ARB_CNT_W=32.
//  Sub-module mem_arb_perf_cnt: the two wrapping counters, instantiated only under the macro.
// TESTING
//  1 IF only, if_addr=0x10, memory acks 1 cycle after mem_req -> if_gnt cyc0, mem_req cyc1-2,
//    if_valid cyc3 with if_rdata=mem word @0x10.
//  2 IF and MA (load 0x200) together in IDLE -> ma_gnt first, IF granted in IDLE after ma_valid.
//  3 ma_req held continuously, if_req high, MAX_MA_BURST=4 -> exactly 4 MA grants, then if_gnt.
//  4 store ma_addr=0x300 wdata=0xDEADBEEF wstrb=4'b0011 -> mem_we=1, mem_wstrb=0011 held until ack;
//    ma_valid pulses, ma_rdata unchanged.
//  5 reset asserted while BUSY_MA with mem_req high -> mem_req=0 next edge; ack 2 cycles later ignored,
//    no ma_valid.
//  6 with MEM_ARB_PERF_CNT_EN, scenario 2 -> perf_conflict=1, perf_if_wait = MA occupancy cycles;
//    without macro both read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MA memory port arbiter: FSM states, ownership and counter width.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_MA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MA   = 2'd2
    } owner_e;

    function automatic owner_e state_owner(input arb_state_e s);
        case (s)
            BUSY_IF: return OWN_IF;
            BUSY_MA: return OWN_MA;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Two free-running wrapping event counters for the arbiter; instantiated only when
// MEM_ARB_PERF_CNT_EN is defined.
module mem_arb_perf_cnt
    import mem_arb_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_wait_inc,
    input  logic                     conflict_inc,
    output logic [MEM_ARB_CNT_W-1:0] perf_if_wait,
    output logic [MEM_ARB_CNT_W-1:0] perf_conflict
);

    localparam logic [MEM_ARB_CNT_W-1:0] CNT_ONE = MEM_ARB_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_wait  <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_wait_inc)  perf_if_wait  <= perf_if_wait + CNT_ONE;
            if (conflict_inc) perf_conflict <= perf_conflict + CNT_ONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF (fetch) and MA (load/store); MA has priority, bounded
// by MAX_MA_BURST. Define MEM_ARB_PERF_CNT_EN to build the perf_if_wait/perf_conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_MA_BURST = 4,  // legal range 1..15
    parameter int unsigned AW           = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_req,
    input  logic [AW-1:0]            if_addr,
    output logic                     if_gnt,
    output logic                     if_valid,
    output logic [31:0]              if_rdata,
    input  logic                     ma_req,
    input  logic                     ma_we,
    input  logic [AW-1:0]            ma_addr,
    input  logic [31:0]              ma_wdata,
    input  logic [3:0]               ma_wstrb,
    output logic                     ma_gnt,
    output logic                     ma_valid,
    output logic [31:0]              ma_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [MEM_ARB_CNT_W-1:0] perf_if_wait,
    output logic [MEM_ARB_CNT_W-1:0] perf_conflict
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_MA_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       grant_if, grant_ma;
    logic       burst_full, if_req_eff, any_valid;

    assign burst_full = (burst_q == BURST_MAX);
    // A requester still shows its req during its own valid cycle; that is not a new request.
    assign if_req_eff = if_req & ~if_valid;
    assign any_valid  = if_valid | ma_valid;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        grant_if = 1'b0;
        grant_ma = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The completion cycle is a bubble: a stale req cannot be re-granted, and an MA
                // stream keeps its turn until the burst limit hands the port to IF.
                if (!reset && !any_valid) begin
                    if (ma_req && !(if_req && burst_full)) begin
                        grant_ma = 1'b1;
                        state_d  = BUSY_MA;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                        state_d  = BUSY_IF;
                    end
                end
                if (grant_if || !if_req_eff) begin
                    burst_d = '0;
                end else if (grant_ma && !burst_full) begin
                    burst_d = burst_q + 4'd1;
                end
            end
            BUSY_IF, BUSY_MA: begin
                if (mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_gnt = grant_if;
    assign ma_gnt = grant_ma;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_valid  <= 1'b0;
            ma_valid  <= 1'b0;
            if_rdata  <= '0;
            ma_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            ma_valid <= 1'b0;
            if (grant_ma) begin
                mem_req   <= 1'b1;
                mem_we    <= ma_we;
                mem_addr  <= ma_addr;
                mem_wdata <= ma_we ? ma_wdata : 32'h0;
                mem_wstrb <= ma_we ? ma_wstrb : 4'b0000;
            end else if (grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'h0;
                mem_wstrb <= 4'b0000;
            end else if (mem_req && mem_ack) begin
                // An ack with mem_req low (spurious, or after a reset abort) never gets here.
                mem_req <= 1'b0;
                if (state_owner(state_q) == OWN_IF) begin
                    if_rdata <= mem_rdata;
                    if_valid <= 1'b1;
                end else if (state_owner(state_q) == OWN_MA) begin
                    if (!mem_we) ma_rdata <= mem_rdata;
                    ma_valid <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic ma_req_eff, if_wait_inc, conflict_inc;

    assign ma_req_eff   = ma_req & ~ma_valid;
    // IF owns the memory from its grant cycle until its access completes.
    assign if_wait_inc  = if_req_eff && (state_owner(state_q) != OWN_IF) && !grant_if;
    assign conflict_inc = (state_q == IDLE) && if_req_eff && ma_req_eff;

    mem_arb_perf_cnt u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .if_wait_inc  (if_wait_inc),
        .conflict_inc (conflict_inc),
        .perf_if_wait (perf_if_wait),
        .perf_conflict(perf_conflict)
    );
`else
    assign perf_if_wait  = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random IF/MA requesters, a random-latency memory,
// and a requester-level reference model for data, arbitration order and perf counters.
module tb_mem_port_arbiter;

    localparam int unsigned MAX      = 4;
    localparam int          MAX_WAIT = 400;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        ma_req, ma_we, ma_gnt, ma_valid;
    logic [31:0] ma_addr, ma_wdata, ma_rdata;
    logic [3:0]  ma_wstrb;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] perf_if_wait, perf_conflict;

    mem_port_arbiter #(.MAX_MA_BURST(MAX), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata), .ma_wstrb(ma_wstrb),
        .ma_gnt(ma_gnt), .ma_valid(ma_valid), .ma_rdata(ma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .perf_if_wait(perf_if_wait), .perf_conflict(perf_conflict)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event did not occur", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] if_exp_q[$];
    logic [31:0] ma_exp_q[$];
    mem_txn_t    mem_exp_q[$];
    mem_txn_t    cur_txn;
    logic [31:0] ma_last;
    bit          if_busy, ma_busy, ack_if_prev, ack_ma_prev, gnt_prev, prev_mem_req;
    int          ma_since, burst_seen, m_if_wait, m_conflict;
    int          cyc, last_if_gnt_cyc, last_if_valid_cyc;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic clear_model();
        if_exp_q.delete();
        ma_exp_q.delete();
        mem_exp_q.delete();
        ma_last     = 32'h0;
        if_busy     = 0;
        ma_busy     = 0;
        ack_if_prev = 0;
        ack_ma_prev = 0;
        gnt_prev    = 0;
        ma_since    = 0;
        m_if_wait   = 0;
        m_conflict  = 0;
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_arr [logic [31:0]];
    bit          slave_en  = 1;
    int          fixed_lat = -1;
    int          wait_cnt  = -1;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (slave_en) begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                end else if (mem_req) begin
                    if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    if (wait_cnt == 0) begin
                        logic [31:0] w;
                        w = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : init_word(mem_addr);
                        mem_rdata = w;
                        if (mem_we) begin
                            for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                            mem_arr[mem_addr] = w;
                        end
                        mem_ack  = 1'b1;
                        wait_cnt = -1;
                    end else begin
                        wait_cnt--;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    mem_rdata = $urandom;
                    mem_ack   = 1'b1;  // spurious ack while idle
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        bit ack_any_prev;
        cyc++;
        ack_any_prev = ack_if_prev || ack_ma_prev;
        if (reset) begin
            prev_mem_req = mem_req;
        end else begin
            if (if_req && !if_valid && !if_busy && !if_gnt) m_if_wait++;
            if (if_req && ma_req && !if_valid && !ma_valid && !if_busy && !ma_busy) m_conflict++;

            if (if_valid || ack_if_prev) check("if_valid_timing", 32'(if_valid), 32'(ack_if_prev));
            if (ma_valid || ack_ma_prev) check("ma_valid_timing", 32'(ma_valid), 32'(ack_ma_prev));
            if (if_valid) begin
                if_busy = 0;
                last_if_valid_cyc = cyc;
                if (if_exp_q.size() == 0) fail_now("if_valid_expected");
                else check("if_rdata", if_rdata, if_exp_q.pop_front());
            end
            if (ma_valid) begin
                ma_busy = 0;
                if (ma_exp_q.size() == 0) fail_now("ma_valid_expected");
                else check("ma_rdata", ma_rdata, ma_exp_q.pop_front());
            end

            if (if_gnt && ma_gnt) fail_now("single_grant");
            if (gnt_prev) check("mem_req_after_gnt", 32'(mem_req), 32'd1);
            if (ack_any_prev) check("mem_req_drop_after_ack", 32'(mem_req), 32'd0);
            if (if_gnt) begin
                if (ma_req && !ma_valid && !ma_busy) check("ma_burst_before_if", ma_since, MAX);
                burst_seen      = ma_since;
                ma_since        = 0;
                if_busy         = 1;
                last_if_gnt_cyc = cyc;
                mem_exp_q.push_back('{1'b0, if_addr, 32'h0, 4'h0});
            end
            if (ma_gnt) begin
                if (if_req && !if_valid) begin
                    check("ma_gnt_within_limit", 32'(ma_since < int'(MAX)), 32'd1);
                    ma_since++;
                end
                ma_busy = 1;
                mem_exp_q.push_back('{ma_we, ma_addr, ma_we ? ma_wdata : 32'h0, ma_we ? ma_wstrb : 4'h0});
            end
            if (!if_req) ma_since = 0;
            gnt_prev = if_gnt || ma_gnt;

            if (mem_req && !prev_mem_req) begin
                if (mem_exp_q.size() == 0) begin
                    fail_now("mem_req_expected");
                end else begin
                    cur_txn = mem_exp_q.pop_front();
                    check("mem_addr", mem_addr, cur_txn.addr);
                    check("mem_we", 32'(mem_we), 32'(cur_txn.we));
                    check("mem_wstrb", 32'(mem_wstrb), 32'(cur_txn.wstrb));
                    if (cur_txn.we) check("mem_wdata", mem_wdata, cur_txn.wdata);
                end
            end
            if (mem_req && mem_ack) begin
                check("mem_addr_held", mem_addr, cur_txn.addr);
                check("mem_wstrb_held", 32'(mem_wstrb), 32'(cur_txn.wstrb));
            end
            ack_if_prev  = mem_req && mem_ack && if_busy;
            ack_ma_prev  = mem_req && mem_ack && ma_busy;
            prev_mem_req = mem_req;
        end
    end

    // ---------------- requester tasks ----------------
    task automatic if_xfer(input logic [31:0] addr, input bit hold);
        int t = 0;
        if_exp_q.push_back(init_word(addr));
        if_addr = addr;
        if_req  = 1'b1;
        do begin @(posedge clk); #1; t++; end while (!if_valid && t < MAX_WAIT);
        if (!if_valid) fail_now("if_valid_timeout");
        @(posedge clk); #1;
        if (!hold) if_req = 1'b0;
    endtask

    task automatic ma_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit hold);
        int t = 0;
        if (we) begin
            logic [31:0] w;
            w = ref_rd(addr);
            for (int b = 0; b < 4; b++) if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[addr] = w;
        end else begin
            ma_last = ref_rd(addr);
        end
        ma_exp_q.push_back(ma_last);  // a store leaves ma_rdata at the last load value
        ma_we    = we;
        ma_addr  = addr;
        ma_wdata = wdata;
        ma_wstrb = wstrb;
        ma_req   = 1'b1;
        do begin @(posedge clk); #1; t++; end while (!ma_valid && t < MAX_WAIT);
        if (!ma_valid) fail_now("ma_valid_timeout");
        @(posedge clk); #1;
        if (!hold) ma_req = 1'b0;
    endtask

    task automatic if_agent(input int n, input int min_gap, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(min_gap, max_gap);
            if (gap > 0) begin if_req = 1'b0; repeat (gap) @(posedge clk); #1; end
            if_xfer(32'(4 * $urandom_range(0, 63)), 1'b1);
        end
        if_req = 1'b0;
    endtask

    task automatic ma_agent(input int n, input int min_gap, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(min_gap, max_gap);
            if (gap > 0) begin ma_req = 1'b0; repeat (gap) @(posedge clk); #1; end
            ma_xfer(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
        ma_req = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        if_req = 1'b0;
        ma_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_perf(input string tag);
`ifdef MEM_ARB_PERF_CNT_EN
        check({tag, "_perf_if_wait"}, perf_if_wait, 32'(m_if_wait));
        check({tag, "_perf_conflict"}, perf_conflict, 32'(m_conflict));
`else
        check({tag, "_perf_if_wait"}, perf_if_wait, 32'h0);
        check({tag, "_perf_conflict"}, perf_conflict, 32'h0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        ma_req = 1'b0; ma_we = 1'b0; ma_addr = '0; ma_wdata = '0; ma_wstrb = '0;
        clear_model();
        repeat (2) @(posedge clk); #1;
        check("rst_if_gnt", 32'(if_gnt), 0);
        check("rst_ma_gnt", 32'(ma_gnt), 0);
        check("rst_valids", {30'h0, if_valid, ma_valid}, 0);
        check("rst_mem_req_we", {30'h0, mem_req, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ma_rdata", ma_rdata, 0);
        check_perf("rst");
        reset = 1'b0;
        clear_model();

        // IF alone, memory acks one cycle after mem_req: grant cycle 0, valid cycle 3.
        fixed_lat = 1;
        @(posedge clk); #1;
        if_xfer(32'h10, 1'b0);
        check("if_only_latency", 32'(last_if_valid_cyc - last_if_gnt_cyc), 32'd3);

        // IF and MA load arrive together: MA first, IF after; perf sees one conflict.
        do_reset();
        fork
            ma_xfer(1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
            if_xfer(32'h20, 1'b0);
        join
`ifdef MEM_ARB_PERF_CNT_EN
        check("both_perf_conflict", perf_conflict, 32'd1);
        check("both_perf_if_wait", perf_if_wait, 32'd4);
`endif
        check_perf("both");

        // Continuous MA with IF pending: exactly MAX MA grants before IF.
        fixed_lat = -1;
        fork
            ma_agent(MAX + 2, 0, 0);
            if_xfer(32'h40, 1'b0);
        join
        check("burst_limit_count", 32'(burst_seen), MAX);

        // Store keeps ma_rdata; a following load sees the merged bytes.
        ma_xfer(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
        ma_xfer(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 1'b0);
        ma_xfer(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);

        fork
            if_agent(40, 1, 6);
            ma_agent(60, 0, 3);
        join
        repeat (3) @(posedge clk); #1;
        check_perf("rand_a");

        // Reset while MA owns the memory: mem_req drops, a late ack is ignored.
        slave_en = 0;
        mem_ack  = 1'b0;
        ma_we = 1'b0; ma_addr = 32'h220; ma_req = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!mem_req && t < 20);
        if (!mem_req) fail_now("abort_mem_req_rise");
        reset  = 1'b1;
        ma_req = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_req", 32'(mem_req), 0);
        reset = 1'b0;
        clear_model();
        @(posedge clk); #1;
        mem_rdata = 32'hBAD0_BAD0;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_ma_valid", 32'(ma_valid), 0);
            @(posedge clk); #1;
        end
        check("abort_ma_rdata", ma_rdata, 0);
        slave_en = 1;

        fork
            if_agent(20, 1, 3);
            ma_agent(80, 0, 0);
        join
        repeat (3) @(posedge clk); #1;
        check_perf("rand_b");
        check("queues_drained", 32'(if_exp_q.size() + ma_exp_q.size() + mem_exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
